bus_timer: RTL
==============

Name: bus_timer

Overview:
- Memory-mapped countdown timer that responds to the CPU data bus: m_data_addr, m_data_wdata, m_data_byteen and m_data_rdata, routed through the bridge.
- Drives one bit of the CPU's hw_int vector.
- Software programs PRESET and CTRL; the block counts down and raises an interrupt at zero, either once or with periodic auto-reload.
- Intended as the first peripheral behind the bridge, serving the CP0 interrupt path end-to-end.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base byte address; registers occupy BASE_ADDR to BASE_ADDR+0xB.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  32  byte address from CPU data port
- byteen  input  4  per-byte write enable; 0 means no write
- wdata  input  32  write data, already lane-aligned by CPU
- rdata  output  32  read data, combinational from addr
- irq  output  1  interrupt request to hw_int, registered

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Register map:
  - hit = (addr[31:4] == BASE_ADDR[31:4]) && addr[3:2] != 2'b11.
  - Offset 0x0 is CTRL: bit0 EN, bits2:1 MODE, bit3 IM, bits31:4 read 0.
  - Offset 0x4 is PRESET, 32-bit, R/W.
  - Offset 0x8 is COUNT, read-only; writes to it are ignored.
- Writes:
  - Taken at posedge when hit && byteen != 0.
  - Each byte lane i updates only if byteen[i] is set.
  - CTRL bits 31:4 are never stored.
- Reads:
  - rdata = selected register when hit, else 32'h0.
  - Zero latency, because the CPU samples rdata in the same M-stage cycle.
  - A read in the cycle of a write returns the old value.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0.
- FSM, 2-bit, states IDLE/LOAD/CNT/INT. Each transition below takes effect at the next posedge.
  - IDLE: if CTRL.EN, go to LOAD; else hold. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT. If EN was cleared this cycle, go to IDLE instead.
  - CNT:
    - If !EN: go to IDLE; COUNT freezes.
    - Else if COUNT > 1: COUNT <= COUNT - 1.
    - Else (COUNT is 1 or 0): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT with MODE != 1 (one-shot): CTRL.EN <= 0; go to IDLE; irq_flag stays set.
  - INT with MODE == 1 (periodic): irq_flag <= 0; go to LOAD. EN is unchanged.
- irq: irq = irq_flag & CTRL.IM, taken from the registered flag; it is not glitching logic.
  - One-shot mode: irq holds high until a bus write to CTRL or PRESET clears irq_flag.
  - Periodic mode: irq is a single-cycle pulse.
- Latency: EN=1 written at edge t with PRESET=P≥1:
  - LOAD during cycle t+1; COUNT=P from t+2.
  - COUNT=1 at t+P+1.
  - COUNT=0, state INT and irq=1 at t+P+2.
  - PRESET=0 behaves like PRESET=1.
- Periodic interval between irq pulses: P+2 cycles (INT, LOAD, then P CNT cycles).
- Simultaneous events:
  - A bus write to CTRL in the same cycle the FSM clears EN (INT, one-shot): the bus write wins.
  - The irq_flag clear caused by a bus write beats the flag set from CNT in the same cycle.
  - A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
  - A COUNT write during CNT leaves COUNT unchanged.
- Reset mid-count: everything returns to reset values on that edge and irq drops.

Decomposition:
- Shared package (timer_defs) holds:
  - offset constants TMR_CTRL=2'd0, TMR_PRESET=2'd1, TMR_COUNT=2'd2;
  - CTRL bit positions EN/MODE/IM;
  - the FSM state encodings;
  - the MODE encodings (ONESHOT=0, PERIODIC=1).
- No sub-module: a single module with one byte-merge function for byteen writes.

Test Plan:
- Reset, then read 0x7F00/0x7F04/0x7F08 -> all 0, irq=0.
- Write PRESET=5, then CTRL=0x9 (EN, mode 0, IM) -> COUNT reads 5,4,3,2,1,0; irq rises exactly 7 cycles after the CTRL write edge; CTRL reads 0x8 afterward; irq stays high until a CTRL write of 0x0 drops it next cycle.
- PRESET=3, CTRL=0xB (periodic, IM) -> irq single-cycle pulses every 5 cycles, repeating for at least 3 periods; EN remains 1.
- Mid-count (COUNT=2), write CTRL=0x8 -> state IDLE; COUNT frozen at 2 (or 1, per the edge); irq never asserts. Write CTRL=0x9 -> reloads from PRESET.
- byteen=4'b0010, wdata=0x0000AB00 to PRESET=0x11223344 -> PRESET reads 0x1122AB44. Write to COUNT -> unchanged. Read of 0x7F0C -> rdata=0.
- Assert reset while COUNT=3 in periodic mode with irq pending -> next cycle all registers 0, irq=0, state IDLE.

Source files
------------

// File: rtl/timer_defs.sv
`default_nettype none
// ============================================================================
// Package     : timer_defs
// Description : Shared constants for the bus_timer peripheral: register
//               offsets, CTRL bit positions, mode and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_defs;

  // Word offsets within the timer window (addr[3:2])
  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_PRESET = 2'd1;
  localparam logic [1:0] TMR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE field encodings
  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  // Countdown FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped countdown timer (CTRL / PRESET / COUNT) with
//               one-shot or periodic auto-reload and a registered interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer
  import timer_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // Lane-wise merge of a partial write into an existing 32-bit register
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  state_t      state;
  state_t      state_nxt;

  logic [31:0] count_nxt;
  logic        fsm_set_flag;
  logic        fsm_clr_flag;
  logic        fsm_clr_en;

  logic [1:0]  sel;
  logic        hit;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;

  // Byte-select bits are meaningless for word registers
  logic        unused_addr;
  assign unused_addr = &{1'b0, addr[1:0]};

  assign sel       = addr[3:2];
  assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (sel != 2'b11);
  assign wr        = hit && (byteen != 4'b0000);
  assign wr_ctrl   = wr && (sel == TMR_CTRL);
  assign wr_preset = wr && (sel == TMR_PRESET);
  assign ctrl_en   = ctrl[CTRL_EN];
  assign ctrl_mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

  // Zero-latency read mux; unmapped or missed addresses read as zero
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (sel)
        TMR_CTRL:   rdata = {28'h0, ctrl};
        TMR_PRESET: rdata = preset;
        TMR_COUNT:  rdata = count;
        default:    rdata = 32'h0;
      endcase
    end
  end

  // Next-state and counter datapath for the countdown FSM
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    fsm_set_flag = 1'b0;
    fsm_clr_flag = 1'b0;
    fsm_clr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = preset;
          state_nxt = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          // PRESET of 0 lands here too, so it behaves like 1
          count_nxt    = 32'h0;
          fsm_set_flag = 1'b1;
          state_nxt    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_mode == MODE_PERIODIC) begin
          fsm_clr_flag = 1'b1;
          state_nxt    = ST_LOAD;
        end else begin
          fsm_clr_en = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (ctrl_mode == MODE_ONESHOT) begin
      // Any non-periodic mode value already takes the one-shot path above
    end
  end

  // State and COUNT registers; COUNT is never bus-writable
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= 32'h0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // CTRL register; a bus write overrides the one-shot EN clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'h0;
    end else if (wr_ctrl) begin
      if (byteen[0]) ctrl <= wdata[3:0];
    end else if (fsm_clr_en) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // PRESET register with per-lane write enables
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'h0;
    end else if (wr_preset) begin
      preset <= merge_bytes(preset, wdata, byteen);
    end
  end

  // Interrupt flag; a CTRL/PRESET write acknowledges and beats a new set
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      irq_flag <= 1'b0;
    end else if (fsm_set_flag) begin
      irq_flag <= 1'b1;
    end else if (fsm_clr_flag) begin
      irq_flag <= 1'b0;
    end
  end

  assign irq = irq_flag & ctrl[CTRL_IM];

endmodule
`default_nettype wire
